command_serializer: RTL and testbench

Write-side counterpart of the CP command path: accepts command-stream writes of 1–4 bytes and packs them contiguously into 32-bit words for the GX FIFO write port. The first byte written occupies bits [7:0] of a word; later bytes fill upward. It sits between the CPU/PI write-gather path and the GX FIFO, and back-pressures the writer when the FIFO is full.

---
 rtl/gx_fifo_pkg.sv | 15 +
 rtl/command_serializer_if.sv | 24 ++
 rtl/byte_lane_merge.sv | 26 ++
 rtl/command_serializer.sv | 112 +++++++++++
 tb/tb_command_serializer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/gx_fifo_pkg.sv
// gx_fifo_pkg: shared types and constants for the GX FIFO command serializer
package gx_fifo_pkg;
    localparam int WORD_W = 32;
    localparam int LANES = 4;
    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef logic [2:0] byte_cnt_t;

    typedef enum logic [1:0] {IDLE, PAD, DRAIN, DONE} state_t;

    // ones in the low n byte lanes (n = 0..4; larger values saturate to all lanes)
    function automatic logic [WORD_W-1:0] lane_mask(input byte_cnt_t n);
        return (n >= 3'd4) ? '1 : (32'd1 << {n, 3'b000}) - 32'd1;
    endfunction
endpackage

// File: rtl/command_serializer_if.sv
// command_serializer_if: command-stream write port plus GX FIFO write port
interface command_serializer_if;
    import gx_fifo_pkg::*;
    logic              WriteValid;
    logic              WriteReady;
    byte_cnt_t         WriteBytes;
    logic [WORD_W-1:0] WriteData;
    logic              Flush;
    logic              FlushDone;
    logic              GXFIFOWrite;
    logic              GXFIFOFull;
    logic [WORD_W-1:0] GXFIFOData;
    logic [1:0]        Pending;

    modport slave (
        input  WriteValid, WriteBytes, WriteData, Flush, GXFIFOFull,
        output WriteReady, FlushDone, GXFIFOWrite, GXFIFOData, Pending
    );

    modport master (
        output WriteValid, WriteBytes, WriteData, Flush, GXFIFOFull,
        input  WriteReady, FlushDone, GXFIFOWrite, GXFIFOData, Pending
    );
endinterface

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: appends 1..4 right-aligned bytes to a partial word, splitting off any overflow
module byte_lane_merge
    import gx_fifo_pkg::*;
(
    input  logic [WORD_W-1:0] acc,
    input  logic [1:0]        count,
    input  logic [WORD_W-1:0] data,
    input  byte_cnt_t         bytes,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] rest,
    output logic [1:0]        new_count,
    output logic              full
);
    logic [WORD_W-1:0] payload;
    logic [2:0]        sum;

    // mask both sides so stale lanes never leak in; the overflow shift is 32 when count is 0, which yields zero
    always_comb begin
        payload = data & lane_mask(bytes);
        sum = {1'b0, count} + bytes;
        word = (acc & lane_mask({1'b0, count})) | (payload << {count, 3'b000});
        rest = payload >> {3'd4 - {1'b0, count}, 3'b000};
        new_count = sum[1:0];
        full = sum[2];
    end
endmodule

// File: rtl/command_serializer.sv
// command_serializer: packs 1-4 byte command writes into 32-bit GX FIFO words
// Optional flush (PAD/DRAIN/DONE) is built when COMMAND_SERIALIZER_FLUSH_EN is defined.
module command_serializer
    import gx_fifo_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    command_serializer_if.slave  bus
);
    state_t            state;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] out_word;
    logic [1:0]        count;
    logic              out_valid;
    logic              flush_done;

    logic              push;
    logic              slot_free;
    logic              wr_hs;
    logic              legal;
    logic              pad_acc;
    logic              take;
    byte_cnt_t         m_bytes;
    logic [WORD_W-1:0] m_data;
    logic [WORD_W-1:0] m_word;
    logic [WORD_W-1:0] m_rest;
    logic [1:0]        m_count;
    logic              m_full;

    assign push = out_valid & ~bus.GXFIFOFull;
    assign slot_free = ~out_valid | ~bus.GXFIFOFull;
    assign bus.WriteReady = (state == IDLE) & slot_free;
    assign wr_hs = bus.WriteValid & bus.WriteReady;
    assign legal = (bus.WriteBytes != 3'd0) && (bus.WriteBytes <= 3'd4);
    assign pad_acc = (state == PAD) & slot_free;
    assign take = (wr_hs & legal) | pad_acc;

    // PAD reuses the write merge path with enough zero bytes to complete the word
    assign m_bytes = (state == PAD) ? 3'd4 - {1'b0, count} : bus.WriteBytes;
    assign m_data = (state == PAD) ? {LANES{PAD_BYTE}} : bus.WriteData;

    assign bus.GXFIFOWrite = push;
    assign bus.GXFIFOData = out_word;
    assign bus.FlushDone = flush_done;
    assign bus.Pending = count;

    byte_lane_merge merge (
        .acc      (acc),
        .count    (count),
        .data     (m_data),
        .bytes    (m_bytes),
        .word     (m_word),
        .rest     (m_rest),
        .new_count(m_count),
        .full     (m_full)
    );

`ifndef COMMAND_SERIALIZER_FLUSH_EN
    logic unused_flush;
    assign unused_flush = bus.Flush;
`endif

    // accumulator, output slot and flush sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc <= '0;
            count <= '0;
            out_word <= '0;
            out_valid <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            if (take) begin
                acc <= m_full ? m_rest : m_word;
                count <= m_count;
            end
            if (take && m_full) begin
                out_word <= m_word;
                out_valid <= 1'b1;
            end else if (push) begin
                out_valid <= 1'b0;
            end
            flush_done <= 1'b0;
`ifdef COMMAND_SERIALIZER_FLUSH_EN
            case (state)
                IDLE: begin
                    if (bus.Flush && !wr_hs) begin
                        if (count != 2'd0) begin
                            state <= PAD;
                        end else if (out_valid) begin
                            state <= DRAIN;
                        end else begin
                            state <= DONE;
                            flush_done <= 1'b1;
                        end
                    end
                end
                PAD: if (pad_acc) state <= DRAIN;
                DRAIN: begin
                    if (push || !out_valid) begin
                        state <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`else
            state <= IDLE;
`endif
        end
    end
endmodule

// File: tb/tb_command_serializer.sv
// tb_command_serializer: directed and random checks of command_serializer against a byte-stream model
module tb_command_serializer;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    // reference model: pending bytes in write order plus a one-word output slot
    byte unsigned bq[$];
    logic        slot_v = 1'b0;
    logic [31:0] slot_w = '0;

    always #5 clk = ~clk;

    command_serializer_if bus();

    command_serializer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock of stimulus: drive, check against the model, advance model, step to next edge+1
    task automatic step(input logic v, input logic [2:0] n, input logic [31:0] d, input logic f);
        logic        push_e;
        logic        rdy_e;
        logic [31:0] w;
        bus.WriteValid = v;
        bus.WriteBytes = n;
        bus.WriteData = d;
        bus.GXFIFOFull = f;
        #1;
        push_e = slot_v & ~f;
        rdy_e = ~slot_v | ~f;
        chk("ready", {31'd0, bus.WriteReady}, {31'd0, rdy_e});
        chk("push", {31'd0, bus.GXFIFOWrite}, {31'd0, push_e});
        if (push_e) chk("data", bus.GXFIFOData, slot_w);
        chk("pending", {30'd0, bus.Pending}, bq.size());
        chk("flushdone", {31'd0, bus.FlushDone}, 32'd0);
        if (push_e) slot_v = 1'b0;
        if (v && rdy_e && n >= 3'd1 && n <= 3'd4) begin
            for (int i = 0; i < int'(n); i++) bq.push_back(d[8*i +: 8]);
            if (bq.size() >= 4) begin
                w = '0;
                for (int i = 0; i < 4; i++) w[8*i +: 8] = bq.pop_front();
                slot_w = w;
                slot_v = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.WriteValid = 1'b0;
        bus.WriteBytes = '0;
        bus.WriteData = '0;
        bus.Flush = 1'b0;
        bus.GXFIFOFull = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.WriteReady}, 32'd1);
        chk("rst_push", {31'd0, bus.GXFIFOWrite}, 32'd0);
        chk("rst_data", bus.GXFIFOData, 32'd0);
        chk("rst_flushdone", {31'd0, bus.FlushDone}, 32'd0);
        chk("rst_pending", {30'd0, bus.Pending}, 32'd0);
        reset = 1'b0;

        // four single bytes form one word
        step(1, 1, 32'hFFFF_FF11, 0);
        step(1, 1, 32'h0000_0022, 0);
        step(1, 1, 32'hABCD_EF33, 0);
        step(1, 1, 32'h0000_0044, 0);
        chk("word_1byte", slot_w, 32'h4433_2211);
        step(0, 0, 0, 0);

        // two 3-byte writes: one word out, two bytes left over, then completed by a 2-byte write
        step(1, 3, 32'h77CC_BBAA, 0);
        step(1, 3, 32'h00FF_EEDD, 0);
        chk("word_3byte", slot_w, 32'hDDCC_BBAA);
        step(0, 0, 0, 0);
        step(1, 2, 32'h9999_2211, 0);
        chk("word_carry", slot_w, 32'h2211_FFEE);
        step(0, 0, 0, 0);

        // back-pressure: slot occupied, FIFO full for 5 cycles, completing write waits
        step(1, 4, 32'h0403_0201, 1);
        for (int i = 0; i < 5; i++) step(1, 4, 32'h8877_6655, 1);
        step(1, 4, 32'h8877_6655, 0);
        step(0, 0, 0, 0);

        // flush of a single pending byte
        step(1, 1, 32'h0000_005A, 0);
`ifdef COMMAND_SERIALIZER_FLUSH_EN
        bus.WriteValid = 1'b0;
        bus.Flush = 1'b1;
        #1;
        chk("fl_idle_ready", {31'd0, bus.WriteReady}, 32'd1);
        @(posedge clk);
        #1;
        bus.Flush = 1'b0;
        #1;
        chk("fl_pad_ready", {31'd0, bus.WriteReady}, 32'd0);
        chk("fl_pad_push", {31'd0, bus.GXFIFOWrite}, 32'd0);
        chk("fl_pad_done", {31'd0, bus.FlushDone}, 32'd0);
        @(posedge clk);
        #1;
        #1;
        chk("fl_drain_ready", {31'd0, bus.WriteReady}, 32'd0);
        chk("fl_drain_push", {31'd0, bus.GXFIFOWrite}, 32'd1);
        chk("fl_drain_data", bus.GXFIFOData, 32'h0000_005A);
        chk("fl_drain_done", {31'd0, bus.FlushDone}, 32'd0);
        @(posedge clk);
        #1;
        #1;
        chk("fl_done_pulse", {31'd0, bus.FlushDone}, 32'd1);
        chk("fl_done_ready", {31'd0, bus.WriteReady}, 32'd0);
        chk("fl_done_push", {31'd0, bus.GXFIFOWrite}, 32'd0);
        chk("fl_done_pending", {30'd0, bus.Pending}, 32'd0);
        @(posedge clk);
        #1;
        #1;
        chk("fl_after_done", {31'd0, bus.FlushDone}, 32'd0);
        chk("fl_after_ready", {31'd0, bus.WriteReady}, 32'd1);
        @(posedge clk);
        #1;
        bq.delete();
        slot_v = 1'b0;
`else
        bus.Flush = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        bus.Flush = 1'b0;
        step(1, 3, 32'h0000_0000, 0);
        step(0, 0, 0, 0);
`endif

        // illegal byte counts are handshaken but ignored
        step(1, 1, 32'h0000_00C3, 0);
        step(1, 0, 32'hDEAD_BEEF, 0);
        step(1, 6, 32'hDEAD_BEEF, 0);
        step(1, 7, 32'hDEAD_BEEF, 0);

        // reset with three pending bytes and a full slot
        step(1, 2, 32'h0000_B2B1, 0);
        step(1, 4, 32'hA4A3_A2A1, 1);
        chk("pre_rst_pending", {30'd0, bus.Pending}, 32'd3);
        bus.WriteValid = 1'b0;
        bus.GXFIFOFull = 1'b0;
        #1;
        chk("pre_rst_push", {31'd0, bus.GXFIFOWrite}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_push", {31'd0, bus.GXFIFOWrite}, 32'd0);
        chk("mid_rst_pending", {30'd0, bus.Pending}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.WriteReady}, 32'd1);
        chk("mid_rst_data", bus.GXFIFOData, 32'd0);
        bq.delete();
        slot_v = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        // randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
